counter_mod: RTL
================

Name: counter_mod

Overview:
Parametrised successor to the team's 4-bit enable counter. Adds configurable width and modulus, up/down direction, synchronous load and clear, and a choice of wrap or saturate mode. Provides a terminal-count strobe and sticky overflow/underflow flags. Used as the general-purpose timebase/event counter in lab designs; terminal-count outputs cascade into the enable input of the next stage.

Parameters:
WIDTH, 4, counter width in bits (1..32)
MODULUS, 16, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH
SATURATE, 0, 0 = wrap at the range ends; 1 = hold at the range ends

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
enable  input  1  count enable; counts one step per clk edge while high
up_down  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
clear  input  1  synchronous clear of the count and the sticky flags
count  output  WIDTH  registered count value
tc  output  1  combinational terminal-count strobe
ovf  output  1  sticky overflow flag (registered)
udf  output  1  sticky underflow flag (registered)

Behaviour:
- Reset: clk is the only clock. rst is asynchronous and active-low. While rst=0: count=0, ovf=0, udf=0, independent of clk. tc then follows its equation with count=0.
- Update priority on each rising clk edge with rst=1: clear > load > enable > hold.
- clear=1: count<=0, ovf<=0, udf<=0. load and enable are ignored.
- load=1 (clear=0): count<=load_val. If load_val >= MODULUS, count<=MODULUS-1 (clamp). Flags unchanged. enable is ignored that cycle.
- enable=1, up_down=1:
  - count < MODULUS-1: count<=count+1.
  - count == MODULUS-1, SATURATE=0: count<=0 and ovf<=1.
  - count == MODULUS-1, SATURATE=1: count holds and ovf<=1.
- enable=1, up_down=0:
  - count > 0: count<=count-1.
  - count == 0, SATURATE=0: count<=MODULUS-1 and udf<=1.
  - count == 0, SATURATE=1: count holds and udf<=1.
- enable=0: count and flags hold.
- tc = enable & ~clear & ~load & ((up_down & count==MODULUS-1) | (~up_down & count==0)).
  - tc is combinational with zero latency.
  - tc is high in exactly the cycle whose edge performs the wrap or saturate event.
- Arithmetic is modulo MODULUS, not 2**WIDTH. With MODULUS = 2**WIDTH this reduces to natural binary roll-over.
- count never leaves 0..MODULUS-1 after reset, by construction.
- Flags are sticky. Once set, ovf/udf remain 1 until clear=1 or rst=0. Setting a flag while it is already set has no effect.
- Direction change (up_down toggles) takes effect on the next edge. No extra latency and no lost count.
- rst asserted mid-count: outputs go to reset values immediately. Counting resumes from 0 on the first edge after rst returns to 1.
- Illegal parameters (MODULUS<2 or MODULUS>2**WIDTH): the block must fail elaboration via a generate-time check.

Test Plan:
- WIDTH=4, MODULUS=10, SATURATE=0; rst=0 mid-run at count=7 -> count=0, ovf=0, udf=0 immediately with no clk edge; after release and 3 enabled up edges -> count=3.
- Up wrap: enable=1, up_down=1, from 0 for 10 edges -> counts 1..9 then 0; tc=1 only while count=9; ovf=1 after the 10th edge and stays 1 for 5 more edges.
- Down wrap: load_val=0 loaded, then enable=1, up_down=0 -> next edge count=9, udf=1, tc=1 in the cycle count=0; clear=1 one edge -> count=0, udf=0, ovf=0.
- SATURATE=1, MODULUS=10: count 8, enable up for 4 edges -> 9,9,9,9; ovf=1; tc=1 every cycle at 9; then down 2 edges -> 8,7.
- Priority and clamp: clear=1, load=1, load_val=5 together -> count=0; then load=1, load_val=12, enable=1 -> count=9 (clamped); enable=0 for 3 edges -> count stays 9, tc=0.
- Cascade: two instances with MODULUS=10, where stage B enable = stage A tc, run 100 edges from 0 -> A=0, B=0 and B.ovf=1 after edge 100; B.count=4 after edge 45.

Source files
------------

// File: rtl/counter_mod.sv
// Parametrised up/down counter with an arbitrary modulus, wrap or saturate at the range ends,
// a combinational terminal-count strobe and sticky overflow/underflow flags.
module counter_mod #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter bit     SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  // 64-bit arithmetic so that WIDTH=32 with MODULUS=2**32 is still representable
  localparam longint RANGE_LIMIT = longint'(1) << WIDTH;
  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULUS - 1);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("counter_mod: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > RANGE_LIMIT) begin : g_bad_modulus
      $error("counter_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;
  logic             udf_nxt;

  assign at_max  = (count == COUNT_MAX);
  assign at_zero = (count == '0);

  // Strobe marks the cycle whose edge performs the wrap/saturate event
  assign tc = enable & ~clear & ~load & ((up_down & at_max) | (~up_down & at_zero));

  always_comb begin
    count_nxt = count;
    ovf_nxt   = ovf;
    udf_nxt   = udf;
    if (clear) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
      udf_nxt   = 1'b0;
    end else if (load) begin
      count_nxt = (load_val > COUNT_MAX) ? COUNT_MAX : load_val;
    end else if (enable) begin
      if (up_down) begin
        if (at_max) begin
          ovf_nxt   = 1'b1;
          count_nxt = SATURATE ? count : '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end else begin
        if (at_zero) begin
          udf_nxt   = 1'b1;
          count_nxt = SATURATE ? count : COUNT_MAX;
        end else begin
          count_nxt = count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
      udf   <= udf_nxt;
    end
  end

endmodule
